// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter for the shared BRAM burst port.
// Optional round-robin tie-break enabled by defining MEM_ARB_ROUND_ROBIN_EN; default is fixed D priority.
module mem_arbiter #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 16,
  parameter int BLOCK_OFFSET_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_req_op,
  input  logic                          d_req_op,
  input  logic                          i_rw,
  input  logic                          d_rw,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  input  logic [ADDR_WIDTH-1:0]         d_addr,
  input  logic [DATA_WIDTH-1:0]         i_write,
  input  logic [DATA_WIDTH-1:0]         d_write,
  output logic                          i_grant,
  output logic                          d_grant,
  output logic [DATA_WIDTH-1:0]         i_read,
  output logic [DATA_WIDTH-1:0]         d_read,
  output logic                          i_read_valid,
  output logic                          d_read_valid,
  output logic                          i_write_req,
  output logic                          d_write_req,
  output logic                          i_last,
  output logic                          d_last,
  output logic [BLOCK_OFFSET_WIDTH-1:0] beat,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic                          mem_req_op,
  output logic                          mem_rw,
  output logic [DATA_WIDTH-1:0]         mem_write,
  input  logic [DATA_WIDTH-1:0]         mem_read,
  input  logic                          mem_read_valid,
  input  logic                          mem_write_req_input,
  input  logic                          mem_last
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, TURN} state_t;

  state_t                        state, state_nxt;
  logic [BLOCK_OFFSET_WIDTH-1:0] beat_r;
  logic                          own_i, own_d;
  logic                          act_i, act_d;
  logic                          hs_i, hs_d;
  logic                          pick_i, pick_d;

  assign own_i = (state == GRANT_I);
  assign own_d = (state == GRANT_D);

  // An owner that drops its request is treated as aborted: port released, responses ignored.
  assign act_i = own_i & i_req_op;
  assign act_d = own_d & d_req_op;

  assign hs_i = act_i & (i_rw ? mem_write_req_input : mem_read_valid);
  assign hs_d = act_d & (d_rw ? mem_write_req_input : mem_read_valid);

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_d;

  // Tie goes to whichever client was not served last; reset value means I was last.
  assign pick_d = d_req_op & (~i_req_op | ~last_d);
  assign pick_i = i_req_op & (~d_req_op |  last_d);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_d <= 1'b0;
    end else if (state == IDLE) begin
      if (pick_d)      last_d <= 1'b1;
      else if (pick_i) last_d <= 1'b0;
    end
  end
`else
  assign pick_d = d_req_op;
  assign pick_i = i_req_op & ~d_req_op;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pick_d)      state_nxt = GRANT_D;
        else if (pick_i) state_nxt = GRANT_I;
      end
      GRANT_I: if (!i_req_op || (hs_i && mem_last)) state_nxt = TURN;
      GRANT_D: if (!d_req_op || (hs_d && mem_last)) state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Beat counter restarts whenever the port leaves a grant, so every burst begins at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      beat_r <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != GRANT_I && state_nxt != GRANT_D) beat_r <= '0;
      else if (hs_i || hs_d)                            beat_r <= beat_r + 1'b1;
    end
  end

  assign beat    = beat_r;
  assign i_grant = own_i;
  assign d_grant = own_d;

  assign mem_req_op = act_i | act_d;
  assign mem_addr   = own_i ? i_addr  : (own_d ? d_addr  : '0);
  assign mem_rw     = own_i ? i_rw    : (own_d ? d_rw    : 1'b0);
  assign mem_write  = own_i ? i_write : (own_d ? d_write : '0);

  // Responses pass combinationally to the active owner only.
  assign i_read       = act_i ? mem_read : '0;
  assign d_read       = act_d ? mem_read : '0;
  assign i_read_valid = act_i & ~i_rw & mem_read_valid;
  assign d_read_valid = act_d & ~d_rw & mem_read_valid;
  assign i_write_req  = act_i &  i_rw & mem_write_req_input;
  assign d_write_req  = act_d &  d_rw & mem_write_req_input;
  assign i_last       = act_i & mem_last;
  assign d_last       = act_d & mem_last;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: transaction-level owner/cool-down model predicts every output each cycle.
module tb_mem_arbiter;
  localparam int DW = 32;
  localparam int AW = 16;
  localparam int BW = 2;
  localparam int BURST = 1 << BW;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_req_op, d_req_op, i_rw, d_rw;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] i_write, d_write;
  logic          i_grant, d_grant;
  logic [DW-1:0] i_read, d_read;
  logic          i_read_valid, d_read_valid, i_write_req, d_write_req, i_last, d_last;
  logic [BW-1:0] beat;
  logic [AW-1:0] mem_addr;
  logic          mem_req_op, mem_rw;
  logic [DW-1:0] mem_write, mem_read;
  logic          mem_read_valid, mem_write_req_input, mem_last;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_OFFSET_WIDTH(BW)) dut (
    .clk(clk), .rst(rst),
    .i_req_op(i_req_op), .d_req_op(d_req_op), .i_rw(i_rw), .d_rw(d_rw),
    .i_addr(i_addr), .d_addr(d_addr), .i_write(i_write), .d_write(d_write),
    .i_grant(i_grant), .d_grant(d_grant), .i_read(i_read), .d_read(d_read),
    .i_read_valid(i_read_valid), .d_read_valid(d_read_valid),
    .i_write_req(i_write_req), .d_write_req(d_write_req),
    .i_last(i_last), .d_last(d_last), .beat(beat),
    .mem_addr(mem_addr), .mem_req_op(mem_req_op), .mem_rw(mem_rw), .mem_write(mem_write),
    .mem_read(mem_read), .mem_read_valid(mem_read_valid),
    .mem_write_req_input(mem_write_req_input), .mem_last(mem_last)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: who owns the port (0 none, 1 I, 2 D), whether this is the dead turnaround cycle,
  // beats completed in the current burst, and who was served last.
  int m_owner = 0;
  bit m_turn  = 0;
  int m_beat  = 0;
  bit m_last_d = 0;
  bit rel_i = 0, rel_d = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit ai, ad;
    ai = (m_owner == 1) && i_req_op;
    ad = (m_owner == 2) && d_req_op;
    chk("grants", {i_grant, d_grant}, {m_owner == 1, m_owner == 2});
    chk("mem_req_op", mem_req_op, ai | ad);
    chk("mem_addr", mem_addr, (m_owner == 1) ? i_addr : (m_owner == 2) ? d_addr : '0);
    chk("mem_rw", mem_rw, (m_owner == 1) ? i_rw : (m_owner == 2) ? d_rw : 1'b0);
    chk("mem_write", mem_write, (m_owner == 1) ? i_write : (m_owner == 2) ? d_write : '0);
    chk("i_read", i_read, ai ? mem_read : '0);
    chk("d_read", d_read, ad ? mem_read : '0);
    chk("i_strobes", {i_read_valid, i_write_req, i_last},
        {ai && !i_rw && mem_read_valid, ai && i_rw && mem_write_req_input, ai && mem_last});
    chk("d_strobes", {d_read_valid, d_write_req, d_last},
        {ad && !d_rw && mem_read_valid, ad && d_rw && mem_write_req_input, ad && mem_last});
    chk("beat", beat, m_beat);
  endtask

  task automatic model_step();
    bit req, rw, hs, win_d;
    if (rst) begin
      m_owner = 0; m_turn = 0; m_beat = 0; m_last_d = 0;
    end else if (m_owner != 0) begin
      req = (m_owner == 1) ? i_req_op : d_req_op;
      rw  = (m_owner == 1) ? i_rw : d_rw;
      hs  = req && (rw ? mem_write_req_input : mem_read_valid);
      if (!req) begin
        m_owner = 0; m_turn = 1; m_beat = 0;
      end else if (hs && mem_last) begin
        if (m_owner == 1) rel_i = 1; else rel_d = 1;
        m_owner = 0; m_turn = 1; m_beat = 0;
      end else if (hs) begin
        m_beat = (m_beat + 1) % BURST;
      end
    end else if (m_turn) begin
      m_turn = 0;
    end else if (i_req_op || d_req_op) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      win_d = d_req_op && (!i_req_op || !m_last_d);
`else
      win_d = d_req_op;
`endif
      m_owner  = win_d ? 2 : 1;
      m_last_d = win_d;
      m_beat   = 0;
    end
  endtask

  task automatic drive_clients();
    if (rel_i) begin
      i_req_op = 1'b0; rel_i = 0;
    end else if (!i_req_op) begin
      if ($urandom % 4 == 0) begin
        i_req_op = 1'b1; i_rw = 1'($urandom); i_addr = AW'($urandom);
      end
    end else if (m_owner == 1 && m_beat >= 1 && $urandom % 16 == 0) begin
      i_req_op = 1'b0;
    end
    if (rel_d) begin
      d_req_op = 1'b0; rel_d = 0;
    end else if (!d_req_op) begin
      if ($urandom % 4 == 0) begin
        d_req_op = 1'b1; d_rw = 1'($urandom); d_addr = AW'($urandom);
      end
    end else if (m_owner == 2 && m_beat >= 1 && $urandom % 16 == 0) begin
      d_req_op = 1'b0;
    end
    i_write = $urandom;
    d_write = $urandom;
  endtask

  initial begin
    rst = 1'b1;
    i_req_op = 0; d_req_op = 0; i_rw = 0; d_rw = 0;
    i_addr = '0; d_addr = '0; i_write = '0; d_write = '0;
    mem_read = '0; mem_read_valid = 0; mem_write_req_input = 0; mem_last = 0;

    for (int it = 0; it < 3000; it++) begin
      @(negedge clk);
      if (it < 2) begin
        rst = 1'b1;
      end else if (it < 6) begin
        // Stray BRAM strobes with nobody granted must be discarded.
        rst = 1'b0;
        mem_read = $urandom; mem_read_valid = 1'b1; mem_write_req_input = 1'b1; mem_last = 1'b1;
      end else begin
        rst = ($urandom % 150 == 0);
        drive_clients();
        mem_read            = $urandom;
        mem_read_valid      = 1'($urandom);
        mem_write_req_input = 1'($urandom);
        mem_last            = (m_beat == BURST - 1) || ($urandom % 8 == 0);
      end
      #2;
      if (it >= 2) check_outputs();
      model_step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
